// File: rtl/fifo_pack.sv
// fifo_pack: packs RATIO input words of IN_W bits into one OUT_W = IN_W*RATIO word
// (first input word in the LSBs) and queues the packed words in a DEPTH-entry FIFO.
//
// Ports:
//   clk           - clock, all state updates on the rising edge
//   rstn          - asynchronous active-low reset
//   input_valid   - producer presents data_in
//   input_enable  - block can accept data_in this cycle
//   data_in       - input word (IN_W bits)
//   output_valid  - data_out holds a complete packed word
//   output_enable - consumer takes data_out this cycle
//   data_out      - packed word at the FIFO head (OUT_W bits)
//   level         - number of stored packed words (only with FIFO_PACK_LEVEL_EN)
//
// Optional feature: define FIFO_PACK_LEVEL_EN to add the level output port.

module fifo_pack #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RATIO = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    input_valid,
    output logic                    input_enable,
    input  logic [IN_W-1:0]         data_in,
    output logic                    output_valid,
    input  logic                    output_enable,
    output logic [IN_W*RATIO-1:0]   data_out
`ifdef FIFO_PACK_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

    localparam int unsigned OUT_W = IN_W * RATIO;
    localparam int unsigned IDX_W = $clog2(RATIO);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] pack_q, pack_d;
    logic [OUT_W-1:0] mem_q [DEPTH];

    logic last_beat;
    logic push;
    logic push_word;
    logic pop;

    // Only the completing beat needs free storage; partial beats are always taken.
    // Deliberately independent of output_enable so there is no comb path through.
    assign last_beat    = (idx_q == IDX_LAST);
    assign input_enable = !last_beat || (count_q < CNT_DEPTH);
    assign output_valid = (count_q != '0);
    assign data_out     = mem_q[rd_ptr_q];

    assign push      = input_valid && input_enable;
    assign push_word = push && last_beat;
    assign pop       = output_valid && output_enable;

`ifdef FIFO_PACK_LEVEL_EN
    assign level = count_q;
`endif

    always_comb begin
        idx_d    = idx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pack_d   = pack_q;

        if (push) begin
            pack_d[idx_q*IN_W +: IN_W] = data_in;
            idx_d = last_beat ? '0 : idx_q + IDX_W'(1);
        end
        if (push_word) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_word, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pack_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pack_q   <= pack_d;
            // pack_d already holds the current beat in its top slice
            if (push_word) begin
                mem_q[wr_ptr_q] <= pack_d;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pack.sv
// Directed self-checking bench for fifo_pack at IN_W=8, RATIO=2, DEPTH=4.
// Define FIFO_PACK_LEVEL_EN to also check the level output.

module tb_fifo_pack;

    logic        clk;
    logic        rstn;
    logic        input_valid;
    logic        input_enable;
    logic [7:0]  data_in;
    logic        output_valid;
    logic        output_enable;
    logic [15:0] data_out;
`ifdef FIFO_PACK_LEVEL_EN
    logic [2:0]  level;
`endif

    int n_tests;
    int n_fail;

    fifo_pack #(
        .IN_W  (8),
        .RATIO (2),
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .input_valid   (input_valid),
        .input_enable  (input_enable),
        .data_in       (data_in),
        .output_valid  (output_valid),
        .output_enable (output_enable),
        .data_out      (data_out)
`ifdef FIFO_PACK_LEVEL_EN
        ,
        .level         (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_level(input string tag, input int exp);
`ifdef FIFO_PACK_LEVEL_EN
        check(tag, 32'(level), 32'(exp));
`endif
    endtask

    // Drive inputs, take one rising edge, return 1ns after it.
    task automatic cycle(input logic iv, input logic [7:0] din, input logic oe);
        input_valid   = iv;
        data_in       = din;
        output_enable = oe;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_q[$];
    logic [7:0]  low_byte;
    logic        tb_idx;
    logic [15:0] exp_pops [4];

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rstn          = 1'b0;
        input_valid   = 1'b0;
        output_enable = 1'b0;
        data_in       = '0;
        #12;
        check("rst_ovalid", 32'(output_valid), 32'd0);
        check("rst_dout",   32'(data_out),     32'd0);
        check("rst_ien",    32'(input_enable), 32'd1);
        check_level("rst_level", 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Two bytes form one word, visible one cycle after the completing beat.
        cycle(1'b1, 8'h11, 1'b0);
        check("half_ovalid", 32'(output_valid), 32'd0);
        cycle(1'b1, 8'h22, 1'b0);
        check("pair_ovalid", 32'(output_valid), 32'd1);
        check("pair_dout",   32'(data_out),     32'h2211);
        cycle(1'b0, 8'h00, 1'b1);
        check("pair_drained", 32'(output_valid), 32'd0);

        // Fill to full with 0x01..0x08.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            if (i % 2 == 0) check_level("fill_level", i / 2);
        end
        check("full_head", 32'(data_out),     32'h0201);
        check("full_ien",  32'(input_enable), 32'd1);
        cycle(1'b1, 8'h09, 1'b0);
        check("ninth_ien", 32'(input_enable), 32'd0);
        cycle(1'b1, 8'h0A, 1'b0);
        check("tenth_refused_ien", 32'(input_enable), 32'd0);
        check_level("tenth_level", 4);
        // Pop while the completing beat waits: beat still refused this cycle.
        cycle(1'b1, 8'h0A, 1'b1);
        check("pop_full_head", 32'(data_out),     32'h0403);
        check("pop_full_ien",  32'(input_enable), 32'd1);
        check_level("pop_full_level", 3);
        cycle(1'b1, 8'h0A, 1'b0);
        check("late_push_head", 32'(data_out), 32'h0403);
        check_level("late_push_level", 4);
        exp_pops = '{16'h0605, 16'h0807, 16'h0A09, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (i < 3) check("drain_head", 32'(data_out), 32'(exp_pops[i]));
            else       check("drain_empty", 32'(output_valid), 32'd0);
        end

        // Streaming push/pop: count stays <= 1 and pointers wrap several times.
        tb_idx   = 1'b0;
        low_byte = '0;
        input_valid   = 1'b1;
        output_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 8'h30 + 8'(i);
            #1;
            check("stream_ien", 32'(input_enable), 32'd1);
            if (output_valid) begin
                if (exp_q.size() == 0) check("stream_extra_word", 32'(data_out), 32'hDEAD);
                else check("stream_word", 32'(data_out), 32'(exp_q.pop_front()));
            end
            @(posedge clk);
            if (tb_idx) exp_q.push_back({data_in, low_byte});
            else        low_byte = data_in;
            tb_idx = ~tb_idx;
            #1;
        end
        check("stream_last", 32'(data_out), 32'h4342);
        cycle(1'b0, 8'h00, 1'b1);
        check("stream_empty", 32'(output_valid), 32'd0);
        exp_q.delete();

        // Asynchronous reset mid-operation discards partial and stored words.
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        input_valid = 1'b0;
        check("pre_rst_ovalid", 32'(output_valid), 32'd1);
        rstn = 1'b0;
        #2;
        check("arst_ovalid", 32'(output_valid), 32'd0);
        check("arst_dout",   32'(data_out),     32'd0);
        check("arst_ien",    32'(input_enable), 32'd1);
        check_level("arst_level", 0);
        rstn = 1'b1;
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0);
        check("post_rst_ovalid", 32'(output_valid), 32'd1);
        check("post_rst_dout",   32'(data_out),     32'hBBAA);
        cycle(1'b0, 8'h00, 1'b1);
        check("post_rst_empty", 32'(output_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pack.md
FIFO_PACK -- requirements
Module: fifo_pack

Interface
REQ-001 SHALL have parameter IN_W, default 8: input word width in bits, at least 1.
REQ-002 SHALL have parameter RATIO, default 2: input words packed per output word, at least 2.
REQ-003 SHALL have parameter DEPTH, default 4: number of output-word storage entries, a power of two and at least 2.
REQ-004 SHALL derive OUT_W = IN_W*RATIO locally; OUT_W is not an overridable parameter.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port input_valid, input, 1 bit: producer presents data_in.
REQ-008 SHALL have port input_enable, output, 1 bit: block can accept data_in this cycle.
REQ-009 SHALL have port data_in, input, IN_W bits: input word.
REQ-010 SHALL have port output_valid, output, 1 bit: data_out holds a complete packed word.
REQ-011 SHALL have port output_enable, input, 1 bit: consumer takes data_out this cycle.
REQ-012 SHALL have port data_out, output, OUT_W bits: packed word at the FIFO head.

Function
REQ-013 SHALL define an input transfer as input_valid=1 and input_enable=1 at a rising clk edge; an output transfer as output_valid=1 and output_enable=1 at a rising clk edge.
REQ-014 SHALL hold a packing register and a beat index idx (0..RATIO-1); each input transfer writes data_in into slice [idx*IN_W +: IN_W], so the first word lands in the LSBs.
REQ-015 SHALL increment idx on each input transfer and wrap it from RATIO-1 to 0.
REQ-016 SHALL, on an input transfer with idx=RATIO-1, write the completed word (packing register with the current data_in in the top slice) into storage at wr_ptr, then increment wr_ptr modulo DEPTH and count by 1.
REQ-017 SHALL drive input_enable = (idx != RATIO-1) OR (count < DEPTH); partial beats are always accepted, and only the completing beat needs free space.
REQ-018 SHALL NOT make input_enable depend combinationally on output_enable; a completing beat while count=DEPTH is refused even if a pop occurs in the same cycle.
REQ-019 SHALL drive output_valid = (count != 0) combinationally from registered state.
REQ-020 SHALL drive data_out = storage[rd_ptr] combinationally, so a written word is visible the cycle after its completing beat (latency 1 clk from the last input transfer).
REQ-021 SHALL, on an output transfer, increment rd_ptr modulo DEPTH and decrement count by 1.
REQ-022 SHALL, on a completing push and a pop in the same cycle (count between 1 and DEPTH-1), leave count unchanged and advance both pointers.
REQ-023 SHALL ignore output_enable while output_valid=0, and ignore input_valid while input_enable=0, with no state change from either.
REQ-024 SHALL leave data_out unspecified while output_valid=0, except that it is 0 after reset.

Reset
REQ-025 SHALL, on rstn=0, immediately and without waiting for clk, clear idx, wr_ptr, rd_ptr, count, the packing register and all storage entries to 0.
REQ-026 SHALL, during reset, hold output_valid=0, data_out=0 and input_enable=1.
REQ-027 SHALL discard any partially packed word and all stored words when reset is asserted mid-operation.

Configuration
REQ-028 SHALL, with macro FIFO_PACK_LEVEL_EN defined, add output port level, width $clog2(DEPTH+1), equal to count (0 in reset).
REQ-029 SHALL, without FIFO_PACK_LEVEL_EN, have no level port; all other behaviour is identical.

Verification (defaults IN_W=8, RATIO=2, DEPTH=4)
REQ-030 SHALL check: push 0x11 then 0x22, output_enable=0 -> next cycle output_valid=1, data_out=0x2211.
REQ-031 SHALL check: push 8 bytes 0x01..0x08 with no pops -> count=4; a 9th byte is accepted (idx 0->1); 10th byte sees input_enable=0; pops then yield 0x0201, 0x0403, 0x0605, 0x0807.
REQ-032 SHALL check: FIFO full with idx=1, output_enable=1 -> input_enable stays 0 that cycle; the next cycle input_enable=1 and the push completes.
REQ-033 SHALL check: continuous input_valid=1 with output_enable=1 -> count never exceeds 1, all words in order, pointers wrap past 3 correctly.
REQ-034 SHALL check: rstn pulsed low between clock edges after 3 bytes -> output_valid=0, data_out=0, input_enable=1 at once; the next two bytes 0xAA, 0xBB give 0xBBAA.
REQ-035 SHALL check, with FIFO_PACK_LEVEL_EN: level tracks 0,1,2,3,4,3 across four completed pushes and one pop.
